// File: rtl/fcs_gate_driver.sv
// Complementary gate driver for the FCS-MPC switching decision.
// Adds dead-time, minimum dwell, sticky fault shutdown and HI-entry count.
module fcs_gate_driver #(
  parameter int DEADTIME    = 10,
  parameter int MIN_PULSE   = 20,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        en,
  input  logic        u,
  input  logic        fault,
  input  logic        clr_fault,
  output logic        gate_hi,
  output logic        gate_lo,
  output logic        fault_latched,
  output logic [2:0]  state_o,
  output logic [15:0] sw_count
);

  typedef enum logic [2:0] {
    SAFE  = 3'd0,
    LO    = 3'd1,
    DT_LH = 3'd2,
    HI    = 3'd3,
    DT_HL = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] DW_MAX  = CNT_W'(MIN_PULSE);

  state_t state;
  state_t state_nx;

  logic [SYNC_STAGES-1:0] u_sync;
  logic                   u_s;
  logic                   f_r;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_d;
  logic [15:0]            sw_q;
  logic [15:0]            sw_d;
  logic                   fl_d;
  logic                   hi_d;
  logic                   lo_d;
  logic                   inc_sw;
  logic                   dwell_ok;
  logic                   dt_done;

  assign u_s      = u_sync[SYNC_STAGES-1];
  assign dwell_ok = cnt >= DW_LAST;
  assign dt_done  = cnt >= DT_LAST;

  assign state_o  = state;
  assign sw_count = sw_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= SAFE;
      cnt           <= '0;
      u_sync        <= '0;
      f_r           <= 1'b0;
      fault_latched <= 1'b0;
      gate_hi       <= 1'b0;
      gate_lo       <= 1'b0;
      sw_q          <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_d;
      u_sync        <= (u_sync << 1) | SYNC_STAGES'(u);
      f_r           <= fault;
      fault_latched <= fl_d;
      gate_hi       <= hi_d;
      gate_lo       <= lo_d;
      sw_q          <= sw_d;
    end
  end

  // Fault and disable override everything; restart always re-enters via DT_HL.
  always_comb begin
    state_nx = state;
    if (f_r) begin
      state_nx = SAFE;
    end else if (!en || fault_latched) begin
      state_nx = SAFE;
    end else begin
      case (state)
        SAFE:    state_nx = DT_HL;
        LO:      if (u_s && dwell_ok) state_nx = DT_LH;
        DT_LH:   if (dt_done) state_nx = HI;
        HI:      if (!u_s && dwell_ok) state_nx = DT_HL;
        DT_HL:   if (dt_done) state_nx = LO;
        default: state_nx = SAFE;
      endcase
    end
  end

  always_comb begin
    hi_d   = 1'b0;
    lo_d   = 1'b0;
    inc_sw = (state == DT_LH) && (state_nx == HI);
    unique case (1'b1)
      state_nx == LO: lo_d = 1'b1;
      state_nx == HI: hi_d = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts on every state change; dwell saturates.
  always_comb begin
    cnt_d = cnt;
    if (state_nx != state) begin
      cnt_d = '0;
    end else if (state == DT_LH || state == DT_HL) begin
      cnt_d = cnt + CNT_W'(1);
    end else if ((state == LO || state == HI) && cnt < DW_MAX) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    sw_d = sw_q + 16'(inc_sw);
    fl_d = fault_latched;
    if (f_r) begin
      fl_d = 1'b1;
    end else if (clr_fault) begin
      fl_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_fcs_gate_driver.sv
// Bench for fcs_gate_driver: timestamp-based reference model,
// per-cycle compare, directed scenarios and a randomised soak.
module tb_fcs_gate_driver;

  localparam int DT = 10;
  localparam int MP = 20;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        u = 1'b0;
  logic        fault = 1'b0;
  logic        clr = 1'b0;
  logic        gate_hi;
  logic        gate_lo;
  logic        fl;
  logic [2:0]  st;
  logic [15:0] swc;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  fcs_gate_driver #(
    .DEADTIME(DT),
    .MIN_PULSE(MP),
    .SYNC_STAGES(SS),
    .CNT_W(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .en(en),
    .u(u),
    .fault(fault),
    .clr_fault(clr),
    .gate_hi(gate_hi),
    .gate_lo(gate_lo),
    .fault_latched(fl),
    .state_o(st),
    .sw_count(swc)
  );

  initial forever #5 clk = ~clk;

  // Reference model: phase plus the edge at which it was entered.
  int          cyc = 0;
  int          m_enter = 0;
  int          m_state = 0;
  bit          m_fr = 1'b0;
  bit          m_fl = 1'b0;
  logic [15:0] m_sw = '0;
  bit          uq[$];

  initial begin
    for (int i = 0; i < SS; i++) uq.push_back(1'b0);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_state = 0;
        m_fr    = 1'b0;
        m_fl    = 1'b0;
        m_sw    = '0;
        m_enter = cyc;
        uq      = {};
        for (int i = 0; i < SS; i++) uq.push_back(1'b0);
      end else begin
        bit us;
        bit fl_old;
        int nxt;
        int t;
        us = uq.pop_front();
        uq.push_back(u);
        fl_old = m_fl;
        t      = cyc - m_enter;
        nxt    = m_state;
        if (m_fr) begin
          nxt  = 0;
          m_fl = 1'b1;
        end else begin
          if (clr) m_fl = 1'b0;
          if (!en || fl_old) nxt = 0;
          else begin
            case (m_state)
              0: nxt = 4;
              1: if (us && t >= MP) nxt = 2;
              2: if (t >= DT) nxt = 3;
              3: if (!us && t >= MP) nxt = 4;
              default: if (t >= DT) nxt = 1;
            endcase
          end
        end
        if (m_state == 2 && nxt == 3) m_sw = m_sw + 16'd1;
        if (nxt != m_state) m_enter = cyc;
        m_state = nxt;
        m_fr    = fault;
      end
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare and gate-safety invariants
  bit prev_hi = 1'b0;
  bit prev_lo = 1'b0;
  int low_run = 0;

  initial forever begin
    @(negedge clk);
    if (run) begin
      cmp("state", int'(st), m_state);
      cmp("gate_hi", int'(gate_hi), int'(m_state == 3));
      cmp("gate_lo", int'(gate_lo), int'(m_state == 1));
      cmp("fault_latched", int'(fl), int'(m_fl));
      cmp("sw_count", int'(swc), int'(m_sw));
      cmp("overlap", int'(gate_hi && gate_lo), 0);
      if ((gate_hi && !prev_hi) || (gate_lo && !prev_lo))
        cmp("deadtime_ok", int'(low_run >= DT), 1);
      low_run = (gate_hi || gate_lo) ? 0 : low_run + 1;
      prev_hi = gate_hi;
      prev_lo = gate_lo;
    end
  end

  int hold = 0;
  int enlow = 0;

  initial begin
    rst = 1'b1;
    tick(2);
    run = 1'b1;
    cmp("rst_state", int'(st), 0);
    cmp("rst_hi", int'(gate_hi), 0);
    cmp("rst_lo", int'(gate_lo), 0);
    cmp("rst_fl", int'(fl), 0);
    cmp("rst_sw", int'(swc), 0);
    rst = 1'b0;
    tick(1);
    cmp("idle_safe", int'(st), 0);

    // start-up through DT_HL
    en = 1'b1;
    tick(10);
    cmp("t1_dthl", int'(st), 4);
    cmp("t1_lo_low", int'(gate_lo), 0);
    tick(1);
    cmp("t1_lo_state", int'(st), 1);
    cmp("t1_lo_on", int'(gate_lo), 1);

    // LO -> HI commutation latency
    tick(20);
    u = 1'b1;
    tick(2);
    cmp("t2_lo_still", int'(gate_lo), 1);
    tick(1);
    cmp("t2_lo_off", int'(gate_lo), 0);
    cmp("t2_dtlh", int'(st), 2);
    tick(9);
    cmp("t2_hi_wait", int'(gate_hi), 0);
    tick(1);
    cmp("t2_hi_on", int'(gate_hi), 1);
    cmp("t2_sw", int'(swc), 1);

    // short low pulse dropped, then dwell-limited exit
    tick(5);
    u = 1'b0;
    tick(4);
    u = 1'b1;
    tick(6);
    cmp("t3_pulse_drop", int'(st), 3);
    u = 1'b0;
    tick(4);
    cmp("t3_hi_h19", int'(gate_hi), 1);
    tick(1);
    cmp("t3_exit_h20", int'(st), 4);
    cmp("t3_hi_off", int'(gate_hi), 0);
    tick(10);
    cmp("t3_lo", int'(st), 1);

    // fault shutdown and clear
    u = 1'b1;
    tick(30);
    cmp("t4_hi", int'(st), 3);
    cmp("t4_sw", int'(swc), 2);
    tick(5);
    fault = 1'b1;
    tick(1);
    fault = 1'b0;
    cmp("t4_edge1", int'(st), 3);
    tick(1);
    cmp("t4_safe", int'(st), 0);
    cmp("t4_gates", int'(gate_hi | gate_lo), 0);
    cmp("t4_fl", int'(fl), 1);
    tick(5);
    cmp("t4_no_restart", int'(st), 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    cmp("t4_clr", int'(fl), 0);
    tick(1);
    cmp("t4_restart", int'(st), 4);
    tick(10);
    cmp("t4_lo", int'(st), 1);
    u = 1'b0;

    // fault beats a concurrent clear
    fault = 1'b1;
    clr = 1'b1;
    tick(1);
    fault = 1'b0;
    tick(1);
    cmp("t4b_fault_wins", int'(fl), 1);
    clr = 1'b0;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    cmp("t4b_cleared", int'(fl), 0);
    tick(11);
    cmp("t4b_lo", int'(st), 1);

    // en drop mid dead-time
    u = 1'b1;
    tick(21);
    cmp("en_dtlh", int'(st), 2);
    en = 1'b0;
    tick(1);
    cmp("en_safe", int'(st), 0);
    en = 1'b1;
    u = 1'b0;
    tick(1);
    cmp("en_restart", int'(st), 4);
    tick(10);
    cmp("en_lo", int'(st), 1);

    // sw_count wrap
    force dut.sw_q = 16'hFFFF;
    m_sw = 16'hFFFF;
    tick(1);
    release dut.sw_q;
    cmp("t5_preload", int'(swc), 65535);
    u = 1'b1;
    tick(30);
    cmp("t5_hi", int'(st), 3);
    cmp("t5_wrap", int'(swc), 0);

    // randomised soak
    repeat (15000) begin
      if (hold == 0) begin
        u = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 45);
      end else begin
        hold--;
      end
      if (enlow == 0 && $urandom_range(0, 399) == 0)
        enlow = $urandom_range(1, 8);
      en = (enlow == 0);
      if (enlow > 0) enlow--;
      fault = ($urandom_range(0, 799) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 4999) == 0);
      tick(1);
    end
    rst = 1'b0;
    fault = 1'b0;
    clr = 1'b0;
    tick(2);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
